// File: rtl/alu_stream_engine.sv
// ALU stream engine: queued instructions feed a registered ALU stage with an
// optional accumulator source for operand A and a downstream valid/ready output.
module alu_stream_engine #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [2*WIDTH+2:0]   in_inst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 acc_mode,
  input  logic                 flush,
  output logic [WIDTH-1:0]     out_result,
  output logic [2:0]           out_flags,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 level,
  output logic [15:0]          res_count
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_NOT = 3'd5,
    OP_SHL = 3'd6,
    OP_SHR = 3'd7
  } opcode_t;

  logic [2*WIDTH+2:0] mem [DEPTH];
  logic [AW:0]        wr_ptr;
  logic [AW:0]        rd_ptr;
  logic               empty;
  logic               full;
  logic               push;
  logic               pop;
  logic [WIDTH-1:0]   acc;

  logic [2*WIDTH+2:0] head;
  opcode_t            op;
  logic [WIDTH-1:0]   op_a;
  logic [WIDTH-1:0]   op_b;
  logic [WIDTH:0]     ext;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_c;
  logic               alu_v;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign in_ready = !full;
  assign push     = in_valid && in_ready && !flush;
  assign pop      = !empty && (!out_valid || out_ready) && !flush;
  assign level    = empty && !out_valid;

  assign head = mem[rd_ptr[AW-1:0]];
  assign op   = opcode_t'(head[2*WIDTH+2:2*WIDTH]);
  assign op_a = acc_mode ? acc : head[2*WIDTH-1:WIDTH];
  assign op_b = head[WIDTH-1:0];

  // Instruction storage; contents are don't-care outside the pointer window.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= in_inst;
  end

  // FIFO pointers; flush discards everything queued.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // ALU evaluation of the current head instruction.
  always_comb begin
    ext     = '0;
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    unique case (op)
      OP_ADD: begin
        ext     = {1'b0, op_a} + {1'b0, op_b};
        alu_res = ext[WIDTH-1:0];
        alu_c   = ext[WIDTH];
        alu_v   = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (alu_res[WIDTH-1] != op_a[WIDTH-1]);
      end
      OP_SUB: begin
        ext     = {1'b0, op_a} - {1'b0, op_b};
        alu_res = ext[WIDTH-1:0];
        alu_c   = ext[WIDTH];
        alu_v   = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (alu_res[WIDTH-1] != op_a[WIDTH-1]);
      end
      OP_AND: alu_res = op_a & op_b;
      OP_OR:  alu_res = op_a | op_b;
      OP_XOR: alu_res = op_a ^ op_b;
      OP_NOT: alu_res = ~op_a;
      OP_SHL: begin
        alu_res = {op_a[WIDTH-2:0], 1'b0};
        alu_c   = op_a[WIDTH-1];
      end
      OP_SHR: begin
        alu_res = {1'b0, op_a[WIDTH-1:1]};
        alu_c   = op_a[0];
      end
      default: alu_res = '0;
    endcase
  end

  // Output register, accumulator and downstream handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_result <= '0;
      out_flags  <= '0;
      out_valid  <= 1'b0;
      acc        <= '0;
    end else if (flush) begin
      out_valid  <= 1'b0;
    end else if (pop) begin
      out_result <= alu_res;
      out_flags  <= {alu_c, (alu_res == '0), alu_v};
      out_valid  <= 1'b1;
      acc        <= alu_res;
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end

  // Count of results accepted downstream; a flush suppresses the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_count <= '0;
    end else if (out_valid && out_ready && !flush) begin
      res_count <= res_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_alu_stream_engine.sv
// Scoreboard bench for alu_stream_engine: instructions are queued when
// accepted and results are checked against a reference model on handshake.
module tb_alu_stream_engine;

  localparam int W = 4;
  localparam int D = 4;
  localparam int M = 1 << W;

  logic           clk = 1'b0;
  logic           rst;
  logic [2*W+2:0] in_inst;
  logic           in_valid;
  logic           in_ready;
  logic           acc_mode;
  logic           flush;
  logic [W-1:0]   out_result;
  logic [2:0]     out_flags;
  logic           out_valid;
  logic           out_ready;
  logic           level;
  logic [15:0]    res_count;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         mode;
  } item_t;

  item_t        sb[$];
  int           n_checks = 0;
  int           n_fail = 0;
  int           exp_count = 0;
  logic [W-1:0] model_acc = '0;
  logic         rand_ready = 1'b0;
  item_t        mon_it;
  logic [W+2:0] mon_e;

  alu_stream_engine #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rst(rst), .in_inst(in_inst), .in_valid(in_valid),
    .in_ready(in_ready), .acc_mode(acc_mode), .flush(flush),
    .out_result(out_result), .out_flags(out_flags), .out_valid(out_valid),
    .out_ready(out_ready), .level(level), .res_count(res_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: returns {result, carry, zero, overflow}.
  function automatic logic [W+2:0] model(input item_t it, input logic [W-1:0] acc);
    int ua, ub, sa, sbv, r, s;
    logic c, v;
    ua = it.mode ? int'(acc) : int'(it.a);
    ub = int'(it.b);
    sa = (ua >= M/2) ? ua - M : ua;
    sbv = (ub >= M/2) ? ub - M : ub;
    c = 1'b0;
    v = 1'b0;
    r = 0;
    case (it.op)
      3'd0: begin r = ua + ub; c = (r >= M); r = r % M; s = sa + sbv; v = (s > M/2-1) || (s < -M/2); end
      3'd1: begin c = (ua < ub); r = (ua - ub + M) % M; s = sa - sbv; v = (s > M/2-1) || (s < -M/2); end
      3'd2: r = ua & ub;
      3'd3: r = ua | ub;
      3'd4: r = ua ^ ub;
      3'd5: r = (M - 1) - ua;
      3'd6: begin r = (ua * 2) % M; c = (ua >= M/2); end
      3'd7: begin r = ua / 2; c = (ua % 2) == 1; end
      default: r = 0;
    endcase
    return {r[W-1:0], c, (r == 0), v};
  endfunction

  // A handshake seen here completes on the following rising edge.
  always @(negedge clk) begin
    if (!rst && !flush && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("extra_result", 32'd1, 32'd0);
      end else begin
        mon_it = sb.pop_front();
        mon_e = model(mon_it, model_acc);
        check("result", 32'(out_result), 32'(mon_e[W+2:3]));
        check("flags", 32'(out_flags), 32'(mon_e[2:0]));
        model_acc = mon_e[W+2:3];
        exp_count++;
      end
    end
  end

  // Presents one instruction and returns just after the edge that accepts it.
  task automatic send(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    bit done;
    done = 0;
    in_inst = {op, a, b};
    in_valid = 1'b1;
    for (int g = 0; g < 60 && !done; g++) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back('{op, a, b, acc_mode});
        done = 1;
      end
      @(posedge clk); #1;
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    end
    if (!done) check("push_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle();
    bit done;
    done = 0;
    for (int g = 0; g < 200 && !done; g++) begin
      if (level && sb.size() == 0) done = 1;
      else begin @(posedge clk); #1; end
    end
    if (!done) check("drain_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    sb.delete();
    model_acc = '0;
    exp_count = 0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  logic [2:0]   dir_op [6] = '{3'd0, 3'd1, 3'd1, 3'd6, 3'd7, 3'd5};
  logic [W-1:0] dir_a  [6] = '{4'hF, 4'h8, 4'h3, 4'h8, 4'h1, 4'hF};
  logic [W-1:0] dir_b  [6] = '{4'h1, 4'h1, 4'h3, 4'h0, 4'h0, 4'h0};

  initial begin : main
    logic [15:0]  base;
    logic [W-1:0] held_r;
    logic [2:0]   held_f;
    logic [W+2:0] e;
    rst = 1'b1; in_inst = '0; in_valid = 1'b0; acc_mode = 1'b0;
    flush = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_res_count", 32'(res_count), 32'd0);
    check("rst_out_result", 32'(out_result), 32'd0);
    check("rst_out_flags", 32'(out_flags), 32'd0);
    rst = 1'b0;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_level", 32'(level), 32'd1);

    // ADD overflow case and one-edge latency from acceptance.
    out_ready = 1'b1;
    send(3'd0, 4'b0111, 4'b0001);
    in_valid = 1'b0;
    check("lat_edge_k", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    check("lat_edge_k1", 32'(out_valid), 32'd1);
    check("add_result", 32'(out_result), 32'b1000);
    check("add_flags", 32'(out_flags), 32'b001);
    wait_idle();
    check("res_count_1", 32'(res_count), 32'd1);

    // SUB with borrow.
    send(3'd1, 4'b0010, 4'b0011);
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("sub_result", 32'(out_result), 32'b1111);
    check("sub_flags", 32'(out_flags), 32'b100);
    wait_idle();

    // Boundary operands: carry-out to zero, signed overflow, zero, shifts, NOT.
    for (int i = 0; i < 6; i++) send(dir_op[i], dir_a[i], dir_b[i]);
    in_valid = 1'b0;
    wait_idle();

    // Random stream with random backpressure.
    rand_ready = 1'b1;
    for (int i = 0; i < 24; i++) send(3'($urandom_range(0, 7)), W'($urandom), W'($urandom));
    in_valid = 1'b0;
    rand_ready = 1'b0;
    out_ready = 1'b1;
    wait_idle();
    check("res_count_stream", 32'(res_count), 32'(exp_count));

    // Backpressure: one result held plus DEPTH queued, then drain in order.
    out_ready = 1'b0;
    base = res_count;
    for (int i = 0; i < 5; i++) send(3'(i), W'(i + 3), W'(2 * i + 1));
    check("full_in_ready", 32'(in_ready), 32'd0);
    held_r = out_result;
    held_f = out_flags;
    in_inst = {3'd4, 4'hA, 4'h5};
    in_valid = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    in_valid = 1'b0;
    check("hold_valid", 32'(out_valid), 32'd1);
    check("hold_result", 32'(out_result), 32'(held_r));
    check("hold_flags", 32'(out_flags), 32'(held_f));
    check("hold_in_ready", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    wait_idle();
    check("res_count_drain", 32'(res_count), 32'(base + 16'd5));

    // Accumulator chaining from reset.
    do_reset();
    acc_mode = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) send(3'd0, 4'h9, 4'b0001);
    in_valid = 1'b0;
    wait_idle();
    check("acc_last", 32'(out_result), 32'b0011);
    acc_mode = 1'b0;

    // Flush with a simultaneous push attempt.
    out_ready = 1'b0;
    base = res_count;
    send(3'd0, 4'h2, 4'h5);
    send(3'd4, 4'hC, 4'h3);
    send(3'd3, 4'h1, 4'h8);
    in_inst = {3'd2, 4'hF, 4'hF};
    in_valid = 1'b1;
    flush = 1'b1;
    e = model(sb[0], model_acc);
    model_acc = e[W+2:3];
    sb.delete();
    @(posedge clk); #1;
    flush = 1'b0;
    in_valid = 1'b0;
    check("flush_out_valid", 32'(out_valid), 32'd0);
    check("flush_level", 32'(level), 32'd1);
    check("flush_res_count", 32'(res_count), 32'(base));
    acc_mode = 1'b1;
    out_ready = 1'b1;
    send(3'd0, 4'h0, 4'h0);
    in_valid = 1'b0;
    wait_idle();
    acc_mode = 1'b0;

    // Asynchronous reset while a result is held.
    out_ready = 1'b0;
    send(3'd3, 4'h5, 4'h2);
    send(3'd2, 4'h6, 4'h3);
    in_valid = 1'b0;
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_valid", 32'(out_valid), 32'd0);
    check("async_rst_count", 32'(res_count), 32'd0);
    check("async_rst_level", 32'(level), 32'd1);
    sb.delete();
    model_acc = '0;
    exp_count = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    send(3'd0, 4'h1, 4'h1);
    in_valid = 1'b0;
    wait_idle();
    check("post_rst_count", 32'(res_count), 32'd1);

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
